// File: rtl/tetris_pkg.sv
// Shared types for the piece-movement path: move codes, sequencer states,
// piece state codes and the 5x5 frame type.
package tetris_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    RIGHT = 3'd1,
    LEFT  = 3'd2,
    ROR   = 3'd3,
    ROL   = 3'd4,
    DOWN  = 3'd5
  } move_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    EXEC   = 2'd2,
    LAND   = 2'd3
  } seq_state_t;

  typedef logic [4:0][4:0][2:0] frame_t;

  localparam frame_t FRAME_EMPTY = 75'd0;

  localparam logic [4:0] A1 = 5'd0;
  localparam logic [4:0] A2 = 5'd1;
  localparam logic [4:0] A3 = 5'd2;
  localparam logic [4:0] A4 = 5'd3;
  localparam logic [4:0] B1 = 5'd4;
  localparam logic [4:0] B2 = 5'd5;
  localparam logic [4:0] C1 = 5'd6;
  localparam logic [4:0] C2 = 5'd7;
  localparam logic [4:0] C3 = 5'd8;
  localparam logic [4:0] C4 = 5'd9;
  localparam logic [4:0] D1 = 5'd10;

  // Bit positions of the sticky pending vector.
  localparam int P_RIGHT = 0;
  localparam int P_LEFT  = 1;
  localparam int P_ROR   = 2;
  localparam int P_ROL   = 3;
  localparam int P_DOWN  = 4;

  function automatic move_t pick_move(input logic [4:0] p);
    move_t m;
    m = NONE;
    if (p[P_DOWN]) m = DOWN;
    else if (p[P_ROR]) m = ROR;
    else if (p[P_ROL]) m = ROL;
    else if (p[P_RIGHT]) m = RIGHT;
    else if (p[P_LEFT]) m = LEFT;
    else m = NONE;
    return m;
  endfunction

  function automatic logic [4:0] move_mask(input move_t m);
    logic [4:0] k;
    case (m)
      RIGHT:   k = 5'b00001;
      LEFT:    k = 5'b00010;
      ROR:     k = 5'b00100;
      ROL:     k = 5'b01000;
      DOWN:    k = 5'b10000;
      default: k = 5'b00000;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button followed by a one-cycle
// rising-edge pulse in the clk domain.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= btn;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/move_sequencer.sv
// Drives the combinational frame tracker: holds the live frame and piece,
// issues one queued move per command cycle and reports landing.
module move_sequencer
  import tetris_pkg::*;
#(
  parameter int GRAVITY_TICKS = 25_000_000,
  parameter int SOFT_TICKS    = 2_500_000,
  parameter int CNT_W         = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spawn_valid,
  input  logic [4:0]           spawn_state,
  input  logic [4:0][4:0][2:0] spawn_frame,
  input  logic [2:0]           spawn_color,
  output logic                 spawn_ready,
  input  logic                 btn_right,
  input  logic                 btn_left,
  input  logic                 btn_ror,
  input  logic                 btn_rol,
  input  logic                 soft_drop,
  output move_t                move_o,
  output logic [4:0]           state_o,
  output logic [2:0]           color_o,
  output logic [4:0][4:0][2:0] frame_q,
  input  logic [4:0][4:0][2:0] trk_frame,
  input  logic                 trk_complete,
  output logic                 landed
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic [4:0] pend;
  logic [4:0] pend_nxt;
  logic [4:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] limit;
  logic running;
  logic fire;
  logic pulse_right;
  logic pulse_left;
  logic pulse_ror;
  logic pulse_rol;
  move_t pick;
  move_t move_nxt;
  frame_t frame_nxt;
  logic [4:0] st_nxt;
  logic [2:0] col_nxt;
  logic landed_nxt;

  btn_sync_edge u_sync_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(pulse_right));
  btn_sync_edge u_sync_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(pulse_left));
  btn_sync_edge u_sync_ror   (.clk(clk), .rst(rst), .btn(btn_ror),   .pulse(pulse_ror));
  btn_sync_edge u_sync_rol   (.clk(clk), .rst(rst), .btn(btn_rol),   .pulse(pulse_rol));

  assign limit   = soft_drop ? CNT_W'(SOFT_TICKS) : CNT_W'(GRAVITY_TICKS);
  assign running = (state == ACTIVE) || (state == EXEC);
  // >= so that switching to the shorter soft period fires at once when overdue.
  assign fire    = running && (cnt >= (limit - CNT_W'(1)));
  assign cand    = pend | {fire, pulse_rol, pulse_ror, pulse_left, pulse_right};

  assign spawn_ready = (state == IDLE);

  // Next-state, pending-set and output computation.
  always_comb begin
    state_nxt  = state;
    pend_nxt   = pend;
    cnt_nxt    = cnt;
    move_nxt   = NONE;
    frame_nxt  = frame_q;
    st_nxt     = state_o;
    col_nxt    = color_o;
    landed_nxt = 1'b0;
    pick       = NONE;

    if (running) begin
      cnt_nxt = fire ? {CNT_W{1'b0}} : (cnt + CNT_W'(1));
    end else begin
      cnt_nxt = cnt;
    end

    case (state)
      IDLE: begin
        if (spawn_valid) begin
          frame_nxt = spawn_frame;
          st_nxt    = spawn_state;
          col_nxt   = spawn_color;
          pend_nxt  = 5'b00000;
          cnt_nxt   = {CNT_W{1'b0}};
          state_nxt = ACTIVE;
        end else begin
          pend_nxt  = 5'b00000;
        end
      end
      ACTIVE: begin
        pick = pick_move(cand);
        if (pick != NONE) begin
          move_nxt  = pick;
          pend_nxt  = cand & ~move_mask(pick);
          state_nxt = EXEC;
        end else begin
          pend_nxt  = cand;
        end
      end
      EXEC: begin
        pend_nxt  = cand;
        state_nxt = ACTIVE;
        if (trk_complete) begin
          frame_nxt = trk_frame;
        end else if (move_o == DOWN) begin
          state_nxt  = LAND;
          landed_nxt = 1'b1;
        end else begin
          frame_nxt = frame_q;
        end
      end
      LAND: begin
        pend_nxt  = 5'b00000;
        state_nxt = IDLE;
      end
      default: begin
        pend_nxt  = 5'b00000;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pending bits, gravity counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= 5'b00000;
      cnt     <= {CNT_W{1'b0}};
      move_o  <= NONE;
      frame_q <= FRAME_EMPTY;
      state_o <= 5'd0;
      color_o <= 3'd0;
      landed  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      move_o  <= move_nxt;
      frame_q <= frame_nxt;
      state_o <= st_nxt;
      color_o <= col_nxt;
      landed  <= landed_nxt;
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer with a toy tracker stub and a
// cycle-level reference model of the sequencing rules.
module tb_move_sequencer;
  import tetris_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   spawn_valid = 1'b0;
  logic [4:0] spawn_state = 5'd0;
  frame_t spawn_frame = FRAME_EMPTY;
  logic [2:0] spawn_color = 3'd0;
  logic   spawn_ready;
  logic   btn_right = 1'b0;
  logic   btn_left = 1'b0;
  logic   btn_ror = 1'b0;
  logic   btn_rol = 1'b0;
  logic   soft_drop = 1'b0;
  move_t  move_o;
  logic [4:0] state_o;
  logic [2:0] color_o;
  frame_t frame_q;
  frame_t trk_frame;
  logic   trk_complete;
  logic   landed;
  logic   refuse_left = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  move_sequencer #(.GRAVITY_TICKS(4), .SOFT_TICKS(2), .CNT_W(25)) dut (
    .clk(clk), .rst(rst), .spawn_valid(spawn_valid), .spawn_state(spawn_state),
    .spawn_frame(spawn_frame), .spawn_color(spawn_color), .spawn_ready(spawn_ready),
    .btn_right(btn_right), .btn_left(btn_left), .btn_ror(btn_ror), .btn_rol(btn_rol),
    .soft_drop(soft_drop), .move_o(move_o), .state_o(state_o), .color_o(color_o),
    .frame_q(frame_q), .trk_frame(trk_frame), .trk_complete(trk_complete), .landed(landed)
  );

  always #5 clk = ~clk;

  // Toy tracker: a move adds its code to the frame; LEFT may be refused on
  // demand and DOWN is refused when cell [3][1] holds 3'b101.
  function automatic logic trk_ok(move_t mv, frame_t f, logic ref_l);
    logic ok;
    ok = 1'b1;
    if (mv == LEFT && ref_l) ok = 1'b0;
    if (mv == DOWN && f[3][1] == 3'b101) ok = 1'b0;
    return ok;
  endfunction

  assign trk_frame    = frame_q + 75'(move_o);
  assign trk_complete = trk_ok(move_o, frame_q, refuse_left);

  // ---------------- reference model ----------------
  logic   m_live, m_land;
  move_t  m_fly;
  frame_t m_frame;
  logic [4:0] m_state;
  logic [2:0] m_color;
  logic [7:0] m_pend;
  int     m_grav;
  logic [2:0] m_hist [4];

  function automatic move_t prio_at(int i);
    case (i)
      0: return DOWN;
      1: return ROR;
      2: return ROL;
      3: return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  function automatic move_t btn_move(int b);
    case (b)
      0: return RIGHT;
      1: return LEFT;
      2: return ROR;
      default: return ROL;
    endcase
  endfunction

  task automatic model_reset();
    m_live = 1'b0; m_land = 1'b0; m_fly = NONE; m_frame = FRAME_EMPTY;
    m_state = 5'd0; m_color = 3'd0; m_pend = 8'h00; m_grav = 0;
    for (int b = 0; b < 4; b++) m_hist[b] = 3'b000;
  endtask

  task automatic model_step();
    logic [3:0] raw;
    logic [3:0] pul;
    logic fire;
    int lim;
    raw = {btn_rol, btn_ror, btn_left, btn_right};
    for (int b = 0; b < 4; b++) begin
      pul[b] = m_hist[b][1] & ~m_hist[b][2];
      m_hist[b] = {m_hist[b][1:0], raw[b]};
    end
    if (!m_live) begin
      if (spawn_valid) begin
        m_live = 1'b1; m_frame = spawn_frame; m_state = spawn_state;
        m_color = spawn_color; m_pend = 8'h00; m_grav = 0;
      end
    end else if (m_land) begin
      m_land = 1'b0; m_live = 1'b0; m_pend = 8'h00;
    end else begin
      lim = soft_drop ? 2 : 4;
      fire = (m_grav >= lim - 1);
      m_grav = fire ? 0 : m_grav + 1;
      for (int b = 0; b < 4; b++) if (pul[b]) m_pend[btn_move(b)] = 1'b1;
      if (fire) m_pend[DOWN] = 1'b1;
      if (m_fly != NONE) begin
        if (trk_ok(m_fly, m_frame, refuse_left)) m_frame = m_frame + 75'(m_fly);
        else if (m_fly == DOWN) m_land = 1'b1;
        m_fly = NONE;
      end else begin
        for (int i = 0; i < 5; i++) begin
          if (m_pend[prio_at(i)]) begin
            m_fly = prio_at(i);
            m_pend[prio_at(i)] = 1'b0;
            break;
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic check(string name, logic [74:0] got, logic [74:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_move", 75'(move_o), 75'(m_fly));
    check("model_frame", frame_q, m_frame);
    check("model_state", 75'(state_o), 75'(m_state));
    check("model_color", 75'(color_o), 75'(m_color));
    check("model_landed", 75'(landed), 75'(m_land));
    check("model_ready", 75'(spawn_ready), 75'(!m_live));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    #1 rst = 1'b0;
  endtask

  task automatic spawn(frame_t f, logic [4:0] st, logic [2:0] col);
    spawn_valid = 1'b1; spawn_frame = f; spawn_state = st; spawn_color = col;
    @(posedge clk);
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  frame_t f1, f2;
  int cnt_right, cnt_left, cnt_land;
  logic found;

  initial begin
    f1 = FRAME_EMPTY; f1[2][2] = 3'b110; f1[1][2] = 3'b011;
    f2 = f1; f2[3][1] = 3'b101;

    tick(); tick();
    check("rst_move", 75'(move_o), 75'(NONE));
    check("rst_frame", frame_q, FRAME_EMPTY);
    check("rst_ready", 75'(spawn_ready), 75'd1);
    check("rst_landed", 75'(landed), 75'd0);
    #1 rst = 1'b0;

    // Spawn without input: first gravity DOWN four cycles into ACTIVE.
    spawn(f1, A1, 3'd2);
    check("spawn_ready_low", 75'(spawn_ready), 75'd0);
    check("spawn_color", 75'(color_o), 75'd2);
    tick(); tick(); tick();
    check("no_early_down", 75'(move_o), 75'(NONE));
    tick();
    check("first_down", 75'(move_o), 75'(DOWN));
    tick();
    check("down_applied", frame_q, f1 + 75'd5);

    // Blocked DOWN lands the piece.
    do_reset();
    spawn(f2, A1, 3'd4);
    tick(); tick(); tick(); tick();
    check("blk_down", 75'(move_o), 75'(DOWN));
    tick();
    check("blk_landed", 75'(landed), 75'd1);
    check("blk_frame", frame_q, f2);
    tick();
    check("blk_landed_end", 75'(landed), 75'd0);
    check("blk_ready", 75'(spawn_ready), 75'd1);
    check("blk_frame_hold", frame_q, f2);

    // Priority: RIGHT and ROR edges coincide with a gravity tick.
    do_reset();
    spawn(f1, A1, 3'd1);
    tick();
    btn_right = 1'b1; btn_ror = 1'b1;
    tick(); tick(); tick();
    check("prio_1_down", 75'(move_o), 75'(DOWN));
    btn_right = 1'b0; btn_ror = 1'b0;
    tick(); tick();
    check("prio_2_ror", 75'(move_o), 75'(ROR));
    tick(); tick();
    check("prio_3_down", 75'(move_o), 75'(DOWN));
    tick(); tick();
    check("prio_4_right", 75'(move_o), 75'(RIGHT));
    tick();
    check("prio_frame", frame_q, f1 + 75'd14);

    // Held button gives one RIGHT.
    cnt_right = 0;
    btn_right = 1'b1;
    for (int i = 0; i < 20; i++) begin tick(); if (move_o == RIGHT) cnt_right++; end
    btn_right = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); if (move_o == RIGHT) cnt_right++; end
    check("held_one_right", 75'(cnt_right), 75'd1);

    // Second press while RIGHT is still queued behind rotations merges.
    cnt_right = 0;
    btn_ror = 1'b1; btn_rol = 1'b1; btn_right = 1'b1;
    tick(); btn_right = 1'b0; if (move_o == RIGHT) cnt_right++;
    tick(); btn_right = 1'b1; if (move_o == RIGHT) cnt_right++;
    for (int i = 0; i < 14; i++) begin tick(); if (move_o == RIGHT) cnt_right++; end
    btn_ror = 1'b0; btn_rol = 1'b0; btn_right = 1'b0;
    check("merge_one_right", 75'(cnt_right), 75'd1);

    // Refused LEFT: dropped, no landing.
    cnt_left = 0; cnt_land = 0;
    refuse_left = 1'b1; btn_left = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (move_o == LEFT) cnt_left++;
      if (landed) cnt_land++;
    end
    btn_left = 1'b0; refuse_left = 1'b0;
    check("refuse_one_left", 75'(cnt_left), 75'd1);
    check("refuse_no_land", 75'(cnt_land), 75'd0);
    check("refuse_still_live", 75'(spawn_ready), 75'd0);

    // Asynchronous reset in the middle of EXEC.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_fly != NONE) found = 1'b1;
      else tick();
    end
    check("exec_reached", 75'(found), 75'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_move", 75'(move_o), 75'(NONE));
    check("arst_frame", frame_q, FRAME_EMPTY);
    check("arst_ready", 75'(spawn_ready), 75'd1);
    check("arst_state", 75'(state_o), 75'd0);
    tick();
    #1 rst = 1'b0;

    // Soft drop: a DOWN every two cycles.
    soft_drop = 1'b1;
    spawn(f1, B1, 3'd3);
    tick();
    check("soft_p1", 75'(move_o), 75'(NONE));
    tick();
    check("soft_p2", 75'(move_o), 75'(DOWN));
    tick();
    check("soft_p3", 75'(move_o), 75'(NONE));
    tick();
    check("soft_p4", 75'(move_o), 75'(DOWN));
    tick(); tick();
    check("soft_p6", 75'(move_o), 75'(DOWN));
    check("soft_state", 75'(state_o), 75'(B1));
    soft_drop = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
